// File: rtl/uart_rx_frame_decoder.sv
// Parses SOF / length / payload / checksum frames from the uart byte bus and
// releases a payload on a valid/ready stream only once its checksum verifies.
module uart_rx_frame_decoder #(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF         = 8'h7E,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN     = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_CSUM    = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;

   localparam logic [1:0] ERR_CSUM = 2'b01;
   localparam logic [1:0] ERR_LEN  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   logic [2:0]    state;
   logic          rx_done_q;
   logic [7:0]    len;
   logic [7:0]    sum;
   logic [7:0]    wr_idx;
   logic [7:0]    rd_idx;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    pay_buf [MAX_LEN];

   logic       accept;
   logic [7:0] sum_next;
   logic       len_ok;

   // Edge-detecting the strobe makes any pulse width yield exactly one byte.
   assign accept   = rx_done & ~rx_done_q;
   assign sum_next = sum + rx_byte;
   assign len_ok   = (rx_byte != 8'd0) && (rx_byte <= 8'(MAX_LEN));

   // Derived from the registered state so a reset drops the stream immediately.
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DRAIN);
   assign out_data  = out_valid ? pay_buf[rd_idx[AW-1:0]] : 8'd0;
   assign out_last  = out_valid && (rd_idx == len - 8'd1);

   // NOTE: the payload store carries no reset; it is always rewritten before it is read.
   always_ff @(posedge clk) begin
      if (accept && state == S_PAYLOAD)
         pay_buf[wr_idx[AW-1:0]] <= rx_byte;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rx_done_q <= 1'b0;
         len       <= 8'd0;
         sum       <= 8'd0;
         wr_idx    <= 8'd0;
         rd_idx    <= 8'd0;
         tmo_cnt   <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         drop_cnt  <= 8'd0;
      end else begin
         rx_done_q <= rx_done;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         case (state)
            S_IDLE: begin
               tmo_cnt <= '0;
               if (accept && rx_byte == SOF)
                  state <= S_LEN;
            end
            S_LEN, S_PAYLOAD, S_CSUM: begin
               if (accept) begin
                  tmo_cnt <= '0;
                  if (state == S_LEN) begin
                     if (len_ok) begin
                        len    <= rx_byte;
                        sum    <= rx_byte;
                        wr_idx <= 8'd0;
                        state  <= S_PAYLOAD;
                     end else begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_LEN;
                        state     <= S_IDLE;
                     end
                  end else if (state == S_PAYLOAD) begin
                     sum    <= sum_next;
                     wr_idx <= wr_idx + 8'd1;
                     if (wr_idx == len - 8'd1)
                        state <= S_CSUM;
                  end else if (sum_next == 8'd0) begin
                     frame_ok <= 1'b1;
                     rd_idx   <= 8'd0;
                     state    <= S_DRAIN;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_CSUM;
                     state     <= S_IDLE;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_TMO;
                  state     <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  rd_idx <= rd_idx + 8'd1;
                  if (rd_idx == len - 8'd1)
                     state <= S_IDLE;
               end
               if (accept && drop_cnt != 8'hFF)
                  drop_cnt <= drop_cnt + 8'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_rx_frame_decoder.md
# uart_rx_frame_decoder

Frame decoder placed directly downstream of the `uart` receiver. It consumes the received byte bus (`pc_out_r` qualified by `rx_done`) and parses length-prefixed, checksummed frames. It buffers each payload internally until the checksum is verified. Only verified payloads are released on a valid/ready byte stream; errors are reported as one-cycle pulses with a cause code.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes (1..255).
- `SOF`, 8'h7E: start-of-frame byte.
- `TIMEOUT_CYC`, 100000: maximum idle clock cycles allowed between bytes inside a frame.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset. One clock; `rst` is asynchronous and active-high.
- `rx_byte` in 8: received byte; connects to `pc_out_r`.
- `rx_done` in 1: receive strobe; connects to `rx_done`. Any pulse width is allowed.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: final payload byte of the frame; qualified by `out_valid`.
- `out_ready` in 1: the consumer accepts the byte.
- `frame_ok` out 1: one-cycle pulse; the frame passed the checksum.
- `frame_err` out 1: one-cycle pulse; the frame was aborted.
- `err_code` out 2: cause, valid while `frame_err` is high. 01 = checksum, 10 = length, 11 = timeout.
- `busy` out 1: state is not IDLE.
- `drop_cnt` out 8: bytes dropped while draining; saturates at 255.

## Operation
- **Byte acceptance**
  - `rx_done` is registered into `rx_done_q`.
  - A byte is accepted in a cycle where `rx_done & ~rx_done_q`, with `rx_byte` sampled in that same cycle.
  - A long `rx_done` pulse therefore yields exactly one byte.
- **States:** IDLE, LEN, PAYLOAD, CSUM, DRAIN. The registered state at the accepting edge decides how a byte is handled.
- **IDLE**
  - Byte == `SOF`: go to LEN.
  - Any other byte: ignored, not counted.
- **LEN**
  - Byte L with 1 ≤ L ≤ `MAX_LEN`: store L, set sum = L, clear the write index, go to PAYLOAD.
  - Otherwise: pulse `frame_err` with code 10, go to IDLE.
- **PAYLOAD**
  - Each byte is written to `buf[idx]`, then sum += byte (mod 256) and idx++.
  - After the L-th byte, go to CSUM.
- **CSUM**
  - Byte C is checked for (sum + C) mod 256 == 0.
  - Pass: pulse `frame_ok`, clear the read index, go to DRAIN.
  - Fail: pulse `frame_err` with code 01, go to IDLE.
- **DRAIN**
  - `out_valid` = 1 and `out_data` = `buf[rd]`.
  - A transfer occurs when `out_valid & out_ready`; then rd++.
  - `out_last` = 1 when rd == L−1.
  - The transfer of the last byte returns the state to IDLE.
  - Bytes accepted during DRAIN are discarded and increment `drop_cnt` (saturating). An `SOF` arriving during DRAIN is also dropped.
- **Timeout**
  - In LEN, PAYLOAD and CSUM, a counter clears on every accepted byte and increments otherwise.
  - When it reaches `TIMEOUT_CYC`: pulse `frame_err` with code 11, go to IDLE.
  - DRAIN has no timeout.
- **Buffer:** `MAX_LEN` × 8 register array. It is overwritten by the next frame and is not cleared on error.

## Timing
- **Reset values:** `out_data` 0, `out_valid` 0, `out_last` 0, `frame_ok` 0, `frame_err` 0, `err_code` 0, `busy` 0, `drop_cnt` 0; state IDLE; `rx_done_q` 0.
- **Reset mid-frame or mid-drain:** the frame is discarded silently, with no `frame_err`. `out_valid` drops asynchronously.
- **Result pulses:** `frame_ok` and `frame_err` are registered, high for exactly one cycle, in the cycle after the deciding byte edge.
- **Output latency:** `out_valid` rises in the same cycle as `frame_ok`, one cycle after the checksum byte is accepted.
- **Stream hold:** `out_data` and `out_last` hold stable while `out_valid & ~out_ready`.
- **Drain throughput:** one byte per cycle with `out_ready` tied high.
- **Valid drop:** `out_valid` is 0 in the cycle after the last transfer.
- **Back-to-back frames:** a new `SOF` is recognised starting the cycle the state returns to IDLE.
- **Timeout vs. byte collision:** if a byte is accepted in the same cycle the timeout count reaches `TIMEOUT_CYC`, the byte wins. The counter clears and no timeout is raised.
- **Error pulse vs. new SOF:** an `SOF` accepted in the cycle the `frame_err` pulse is high is processed from IDLE and starts a frame.

## Test plan
- **Good frame:** 7E 02 A5 3C 1D with `out_ready`=1.
  - `frame_ok` pulses once.
  - Stream is A5 then 3C, with `out_last` only on 3C.
  - `busy` returns to 0.
- **Bad checksum:** 7E 02 A5 3C 1E.
  - `frame_err` with `err_code`=01.
  - `out_valid` never asserts.
  - Next frame 7E 01 55 AA decodes OK, streaming 55.
- **Bad length:** 7E 00, then 7E 11 with `MAX_LEN`=16.
  - Two `frame_err` pulses, each code 10.
  - The following byte 55 is ignored in IDLE.
- **Timeout:** 7E 03 11, then silence for `TIMEOUT_CYC` cycles.
  - `frame_err` with code 11.
  - No output bytes.
  - A subsequent valid frame decodes.
- **Backpressure and drops:** 7E 02 A5 3C 1D with `out_ready`=0 while 3 more bytes arrive.
  - `out_data` holds A5.
  - `drop_cnt`=3.
  - Releasing `out_ready` yields A5, 3C.
- **Long strobe and reset:**
  - A 5-cycle `rx_done` pulse is accepted as exactly one byte.
  - Asserting `rst` during PAYLOAD clears `busy` and all outputs, with no `frame_err`.
